// File: rtl/change_dispenser_if.sv
// Signal bundle between the change dispenser and its controller/hopper side.
// The slave modport is the dispenser's view. The master modport is the driver's view.
interface change_dispenser_if;
    logic       start;
    logic [7:0] amount;
    logic [2:0] tube_empty;
    logic       hopper_ack;
    logic       fault_clear;
    logic       eject_req;
    logic [1:0] eject_sel;
    logic       busy;
    logic       done;
    logic       fault;
    logic [7:0] remaining;
    logic [7:0] coins_paid;

    modport slave (
        input  start, amount, tube_empty, hopper_ack, fault_clear,
        output eject_req, eject_sel, busy, done, fault, remaining, coins_paid
    );

    modport master (
        output start, amount, tube_empty, hopper_ack, fault_clear,
        input  eject_req, eject_sel, busy, done, fault, remaining, coins_paid
    );
endinterface

// File: rtl/change_dispenser.sv
// Breaks an owed amount into greedy 5/2/1 coin ejects.
// Each coin is requested from the hopper over a 4-phase req/ack handshake.
module change_dispenser #(
    parameter int unsigned ACK_TIMEOUT = 100000,
    parameter int unsigned GAP_CYCLES  = 1000
) (
    input  logic              clk,
    input  logic              rst,
    change_dispenser_if.slave bus
);

    localparam int unsigned TMAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int          TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SELECT   = 3'd1;
    localparam logic [2:0] S_EJECT    = 3'd2;
    localparam logic [2:0] S_WAIT_LOW = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;
    localparam logic [2:0] S_FAULT    = 3'd6;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_ONE  = 2'b01;
    localparam logic [1:0] SEL_TWO  = 2'b10;
    localparam logic [1:0] SEL_FIVE = 2'b11;

    logic [2:0]    state_q, state_d;
    logic [7:0]    rem_q,   rem_d;
    logic [7:0]    coins_q, coins_d;
    logic [1:0]    sel_q,   sel_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    pick;

    function automatic logic [7:0] coin_val(input logic [1:0] sel);
        case (sel)
            SEL_FIVE: coin_val = 8'd5;
            SEL_TWO:  coin_val = 8'd2;
            SEL_ONE:  coin_val = 8'd1;
            default:  coin_val = 8'd0;
        endcase
    endfunction

    // Largest coin that still fits and whose tube is stocked.
    always_comb begin
        pick = SEL_NONE;
        if (!bus.tube_empty[2] && rem_q >= 8'd5) begin
            pick = SEL_FIVE;
        end else if (!bus.tube_empty[1] && rem_q >= 8'd2) begin
            pick = SEL_TWO;
        end else if (!bus.tube_empty[0] && rem_q >= 8'd1) begin
            pick = SEL_ONE;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        rem_d   = rem_q;
        coins_d = coins_q;
        sel_d   = sel_q;
        timer_d = timer_q;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (bus.start) begin
                    rem_d   = bus.amount;
                    coins_d = 8'd0;
                    state_d = S_SELECT;
                end
            end

            S_SELECT: begin
                timer_d = '0;
                if (rem_q == 8'd0) begin
                    state_d = S_DONE;
                end else if (pick != SEL_NONE) begin
                    sel_d   = pick;
                    state_d = S_EJECT;
                end else begin
                    state_d = S_FAULT;
                end
            end

            S_EJECT: begin
                // An ack seen on the timeout edge still completes the coin.
                if (bus.hopper_ack) begin
                    rem_d   = rem_q - coin_val(sel_q);
                    coins_d = (coins_q == 8'hFF) ? coins_q : coins_q + 8'd1;
                    state_d = S_WAIT_LOW;
                end else if (timer_q == ACK_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_WAIT_LOW: begin
                timer_d = '0;
                if (!bus.hopper_ack) begin
                    state_d = (GAP_CYCLES == 0) ? S_SELECT : S_GAP;
                end
            end

            S_GAP: begin
                if (timer_q == GAP_LAST) begin
                    state_d = S_SELECT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_FAULT: begin
                if (bus.fault_clear) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= 8'd0;
            coins_q <= 8'd0;
            sel_q   <= SEL_NONE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            coins_q <= coins_d;
            sel_q   <= sel_d;
            timer_q <= timer_d;
        end
    end

    assign bus.eject_req  = (state_q == S_EJECT);
    assign bus.eject_sel  = (state_q == S_EJECT) ? sel_q : SEL_NONE;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.fault      = (state_q == S_FAULT);
    assign bus.remaining  = rem_q;
    assign bus.coins_paid = coins_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: coin-plan reference model plus directed scenarios.
// A randomized hopper answers the requests. Reset, start and clear noise are injected at random.
module tb_change_dispenser;

    localparam int ACK_T = 16;
    localparam int GAP_C = 3;

    logic clk = 1'b0;
    logic rst;

    change_dispenser_if bus ();

    change_dispenser #(
        .ACK_TIMEOUT(ACK_T),
        .GAP_CYCLES (GAP_C)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hopper: raises ack hop_delay cycles into a request and drops it hop_release cycles after req falls.
    bit hop_en      = 1'b1;
    int hop_delay   = 3;
    int hop_release = 1;
    int hop_cnt     = 0;

    initial begin
        bus.hopper_ack = 1'b0;
        forever begin
            tick();
            if (!bus.hopper_ack) begin
                if (bus.eject_req && hop_en) begin
                    hop_cnt++;
                    if (hop_cnt >= hop_delay) begin
                        bus.hopper_ack = 1'b1;
                        hop_cnt = 0;
                    end
                end else begin
                    hop_cnt = 0;
                end
            end else if (!bus.eject_req) begin
                hop_cnt++;
                if (hop_cnt >= hop_release) begin
                    bus.hopper_ack = 1'b0;
                    hop_cnt = 0;
                end
            end
        end
    end

    // Recorder for the directed checks.
    logic [1:0] sel_log[$];
    int  cyc       = 0;
    int  req_run   = 0;
    int  done_cyc  = -100;
    int  start_cyc = 0;
    bit  req_prev  = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (bus.eject_req) begin
            if (!req_prev) begin
                sel_log.push_back(bus.eject_sel);
                req_run = 0;
            end
            req_run++;
        end
        if (bus.done)  done_cyc  = cyc;
        if (bus.start) start_cyc = cyc;
        req_prev = bus.eject_req;
    end

    // Reference model. At job start the owed amount becomes a planned coin list using greedy division.
    // The outputs are then predicted from handshake events and the documented latencies.
    typedef enum int {PH_OFF, PH_IDLE, PH_SETTLE, PH_COIN, PH_RELEASE, PH_DONE, PH_FAULT} phase_t;
    phase_t ph = PH_OFF;
    int  coin_q[$];
    int  denom[3] = '{5, 2, 1};
    int  m_rem = 0, m_coins = 0, settle_cnt = 0, req_cnt = 0;
    bit  rst_p = 1'b0, start_p = 1'b0, ack_p = 1'b0, clr_p = 1'b0;
    logic [7:0] amount_p = 8'd0;

    always @(negedge clk) begin
        logic [21:0] exp_v;
        logic [21:0] act_v;
        logic [1:0]  e_sel;
        logic        e_req, e_busy, e_done, e_fault;
        int          r;

        if (rst_p) begin
            ph = PH_IDLE;
            m_rem = 0;
            m_coins = 0;
            coin_q.delete();
        end else begin
            case (ph)
                PH_IDLE: if (start_p) begin
                    m_rem = int'(amount_p);
                    m_coins = 0;
                    coin_q.delete();
                    r = m_rem;
                    for (int k = 0; k < 3; k++) begin
                        if (!bus.tube_empty[2-k]) begin
                            while (r >= denom[k]) begin
                                coin_q.push_back(denom[k]);
                                r -= denom[k];
                            end
                        end
                    end
                    ph = PH_SETTLE;
                    settle_cnt = 1;
                end
                PH_SETTLE: begin
                    if (settle_cnt > 1) begin
                        settle_cnt--;
                    end else if (coin_q.size() > 0) begin
                        ph = PH_COIN;
                        req_cnt = 1;
                    end else if (m_rem == 0) begin
                        ph = PH_DONE;
                    end else begin
                        ph = PH_FAULT;
                    end
                end
                PH_COIN: begin
                    if (ack_p) begin
                        m_rem -= coin_q[0];
                        void'(coin_q.pop_front());
                        if (m_coins < 255) m_coins++;
                        ph = PH_RELEASE;
                    end else if (req_cnt == ACK_T) begin
                        ph = PH_FAULT;
                    end else begin
                        req_cnt++;
                    end
                end
                PH_RELEASE: if (!ack_p) begin
                    ph = PH_SETTLE;
                    settle_cnt = GAP_C + 1;
                end
                PH_DONE:  ph = PH_IDLE;
                PH_FAULT: if (clr_p) ph = PH_IDLE;
                default: ;
            endcase
        end

        if (ph != PH_OFF) begin
            e_req = 1'b0; e_sel = 2'b00; e_busy = (ph != PH_IDLE);
            e_done = (ph == PH_DONE); e_fault = (ph == PH_FAULT);
            if (ph == PH_COIN) begin
                e_req = 1'b1;
                e_sel = (coin_q[0] == 5) ? 2'b11 : (coin_q[0] == 2) ? 2'b10 : 2'b01;
            end
            exp_v = {e_req, e_sel, e_busy, e_done, e_fault, 8'(m_rem), 8'(m_coins)};
            act_v = {bus.eject_req, bus.eject_sel, bus.busy, bus.done, bus.fault,
                     bus.remaining, bus.coins_paid};
            check("cycle_outputs", 32'(act_v), 32'(exp_v));
        end

        rst_p    = rst;
        start_p  = bus.start;
        amount_p = bus.amount;
        ack_p    = bus.hopper_ack;
        clr_p    = bus.fault_clear;
    end

    task automatic start_job(input logic [7:0] amt);
        bus.amount = amt;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.amount = 8'($urandom);
    endtask

    task automatic wait_end(input int budget);
        bit timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (!bus.busy || bus.fault) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        check("job_finished_in_budget", 32'(timed_out), 32'd0);
    endtask

    task automatic clear_fault();
        bus.fault_clear = 1'b1;
        tick();
        bus.fault_clear = 1'b0;
    endtask

    function automatic logic [31:0] log_since(input int base);
        logic [31:0] p = '0;
        for (int i = base; i < sel_log.size(); i++) p = (p << 2) | 32'(sel_log[i]);
        return p;
    endfunction

    initial begin
        int base;
        bit to;
        logic [7:0] amt;

        rst = 1'b1;
        bus.start = 1'b0; bus.amount = 8'd0; bus.tube_empty = 3'b000; bus.fault_clear = 1'b0;
        repeat (3) tick();
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_req", 32'(bus.eject_req), 32'd0);
        rst = 1'b0;
        tick();

        // T1: 8 with full tubes -> 5, 2, 1.
        base = sel_log.size();
        start_job(8'd8);
        wait_end(300);
        check("t1_coin_count", 32'(sel_log.size() - base), 32'd3);
        check("t1_sel_seq", log_since(base), 32'b11_10_01);
        check("t1_remaining", 32'(bus.remaining), 32'd0);
        check("t1_coins_paid", 32'(bus.coins_paid), 32'd3);

        // T2: 4 with the 2-unit tube empty -> four 1-unit coins.
        bus.tube_empty = 3'b010;
        base = sel_log.size();
        start_job(8'd4);
        wait_end(300);
        check("t2_sel_seq", log_since(base), 32'b01_01_01_01);
        check("t2_coins_paid", 32'(bus.coins_paid), 32'd4);
        check("t2_done_seen", 32'(done_cyc > start_cyc), 32'd1);

        // T3: 3 with 2- and 1-unit tubes empty -> fault, no request.
        bus.tube_empty = 3'b011;
        base = sel_log.size();
        start_job(8'd3);
        wait_end(20);
        check("t3_fault", 32'(bus.fault), 32'd1);
        check("t3_no_req", 32'(sel_log.size() - base), 32'd0);
        check("t3_remaining", 32'(bus.remaining), 32'd3);
        clear_fault();
        check("t3_idle_after_clear", 32'(bus.busy), 32'd0);
        check("t3_remaining_kept", 32'(bus.remaining), 32'd3);

        // T4: hopper silent -> request held exactly ACK_T cycles, then fault.
        bus.tube_empty = 3'b000;
        hop_en = 1'b0;
        start_job(8'd5);
        wait_end(100);
        check("t4_fault", 32'(bus.fault), 32'd1);
        check("t4_req_cycles", 32'(req_run), 32'd16);
        check("t4_remaining", 32'(bus.remaining), 32'd5);
        check("t4_coins_paid", 32'(bus.coins_paid), 32'd0);
        clear_fault();
        hop_en = 1'b1;

        // T5: zero amount -> done two cycles after start, no request.
        base = sel_log.size();
        start_job(8'd0);
        tick();
        tick();
        check("t5_done_latency", 32'(done_cyc - start_cyc), 32'd2);
        check("t5_no_req", 32'(sel_log.size() - base), 32'd0);

        // Start pulse while busy must not disturb the current job.
        base = sel_log.size();
        start_job(8'd6);
        tick();
        bus.start = 1'b1; bus.amount = 8'd200;
        tick();
        bus.start = 1'b0;
        wait_end(300);
        check("busy_start_sel_seq", log_since(base), 32'b11_01);
        check("busy_start_remaining", 32'(bus.remaining), 32'd0);

        // Tube emptied mid-eject does not change the coin already selected.
        base = sel_log.size();
        start_job(8'd5);
        tick();
        bus.tube_empty = 3'b100;
        wait_end(300);
        check("tube_change_sel", log_since(base), 32'b11);
        check("tube_change_remaining", 32'(bus.remaining), 32'd0);
        bus.tube_empty = 3'b000;

        // T6: reset in the middle of an eject.
        start_job(8'd7);
        for (int i = 0; i < 10 && !bus.eject_req; i++) tick();
        check("t6_req_seen", 32'(bus.eject_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_reset_outputs",
              32'({bus.eject_req, bus.eject_sel, bus.busy, bus.done, bus.fault,
                   bus.remaining, bus.coins_paid}), 32'd0);
        tick();
        start_job(8'd2);
        wait_end(300);
        check("t6_restart_coins", 32'(bus.coins_paid), 32'd1);
        check("t6_restart_remaining", 32'(bus.remaining), 32'd0);

        // Randomized jobs checked cycle by cycle by the reference model.
        for (int j = 0; j < 150; j++) begin
            hop_en = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 7))
                0:       hop_delay = 16;
                1:       hop_delay = 17;
                default: hop_delay = $urandom_range(1, 6);
            endcase
            hop_release = $urandom_range(1, 4);
            bus.tube_empty = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
            amt = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 25));
            start_job(amt);
            to = 1'b1;
            for (int c = 0; c < 3000; c++) begin
                bus.start = 1'b0; bus.fault_clear = 1'b0; rst = 1'b0;
                if (!bus.busy || bus.fault) begin
                    to = 1'b0;
                    break;
                end
                bus.start       = ($urandom_range(0, 19) == 0);
                bus.amount      = 8'($urandom);
                bus.fault_clear = ($urandom_range(0, 29) == 0);
                rst             = ($urandom_range(0, 499) == 0);
                tick();
            end
            bus.start = 1'b0; bus.fault_clear = 1'b0; rst = 1'b0;
            check("random_job_budget", 32'(to), 32'd0);
            if (bus.fault) clear_fault();
            tick();
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
